// File: rtl/spi_fl_op_seq_if.sv
// Request/response and spi_master_fl controller bundle
// for the flash operation sequencer.
interface spi_fl_op_seq_if;
  logic        req_valid;
  logic        req_ready;
  logic [1:0]  req_op;
  logic [7:0]  req_cmd;
  logic [23:0] req_addr;
  logic [31:0] req_data;
  logic [6:0]  req_nbits;
  logic [3:0]  req_dummy;
  logic [9:0]  req_frame;
  logic        rsp_valid;
  logic [31:0] rsp_data;
  logic        rsp_err;
  logic        busy;
  logic [7:0]  command;
  logic [23:0] address;
  logic [31:0] data_in;
  logic [2:0]  commtype;
  logic [6:0]  ndata_bits;
  logic [9:0]  frame_struct;
  logic [3:0]  dummy_cycles;
  logic        validflag;
  logic [31:0] data_out;
  logic        validflag_out;
  logic        tready;

  modport master (
    input  req_valid, req_op, req_cmd, req_addr,
    input  req_data, req_nbits, req_dummy, req_frame,
    input  data_out, validflag_out, tready,
    output req_ready, rsp_valid, rsp_data, rsp_err,
    output busy, command, address, data_in,
    output commtype, ndata_bits, frame_struct,
    output dummy_cycles, validflag
  );

  modport slave (
    output req_valid, req_op, req_cmd, req_addr,
    output req_data, req_nbits, req_dummy, req_frame,
    output data_out, validflag_out, tready,
    input  req_ready, rsp_valid, rsp_data, rsp_err,
    input  busy, command, address, data_in,
    input  commtype, ndata_bits, frame_struct,
    input  dummy_cycles, validflag
  );
endinterface

// File: rtl/spi_fl_op_seq.sv
// Flash op sequencer: expands one request into
// WREN / main / RDSR-poll transactions for spi_master_fl.
module spi_fl_op_seq #(
  parameter int unsigned POLL_GAP  = 16,
  parameter int unsigned MAX_POLLS = 1000
) (
  input logic             clk,
  input logic             rst,
  spi_fl_op_seq_if.master bus
);

  typedef enum logic [3:0] {
    S_IDLE,
    S_WREN_GO,
    S_WREN_WT,
    S_MAIN_GO,
    S_MAIN_WT,
    S_POLL_GO,
    S_POLL_WT,
    S_POLL_GAP,
    S_DONE
  } state_t;

  state_t state, state_n;

  logic [1:0]  op_q;
  logic [7:0]  cmd_q;
  logic [23:0] addr_q;
  logic [31:0] data_q;
  logic [6:0]  nbits_q;
  logic [3:0]  dummy_q;
  logic [9:0]  frame_q;
  logic [31:0] cap_q;
  logic [31:0] rsp_data_q;
  logic [15:0] poll_cnt;
  logic [15:0] gap_cnt;
  logic        seen_low_q;
  logic        vf_q;
  logic        err_q;

  logic        accept;
  logic        launch;
  logic        in_wt;
  logic        cpl;
  logic        is_wr;
  logic        wip;
  logic        timeout;
  logic        gap_end;
  logic [31:0] cpl_data;

  assign accept = bus.req_valid && (state == S_IDLE);
  assign is_wr  = op_q[0] ^ op_q[1];
  assign launch = bus.tready &&
    (state inside {S_WREN_GO, S_MAIN_GO, S_POLL_GO});
  assign in_wt  =
    state inside {S_WREN_WT, S_MAIN_WT, S_POLL_WT};

  // Completion needs the launch seen (tready low) first;
  // a same-cycle validflag_out beats the held capture.
  assign cpl      = in_wt && seen_low_q && bus.tready;
  assign cpl_data = bus.validflag_out ? bus.data_out
                                      : cap_q;
  assign wip      = cpl_data[0];
  assign timeout  =
    (32'(poll_cnt) + 32'd1) >= MAX_POLLS;
  assign gap_end  =
    (32'(gap_cnt) + 32'd1) >= POLL_GAP;

  assign bus.req_ready = (state == S_IDLE);
  assign bus.busy      = (state != S_IDLE);
  assign bus.rsp_valid = (state == S_DONE);
  assign bus.rsp_data  = rsp_data_q;
  assign bus.rsp_err   = err_q;
  assign bus.validflag = vf_q;

  always_ff @(posedge clk) begin
    if (!rst) state <= S_IDLE;
    else      state <= state_n;
  end

  always_comb begin
    state_n = state;
    unique case (state)
      S_IDLE:
        if (bus.req_valid)
          state_n = (bus.req_op[0] ^ bus.req_op[1])
                    ? S_WREN_GO : S_MAIN_GO;
      S_WREN_GO:
        if (launch) state_n = S_WREN_WT;
      S_WREN_WT:
        if (cpl) state_n = S_MAIN_GO;
      S_MAIN_GO:
        if (launch) state_n = S_MAIN_WT;
      S_MAIN_WT:
        if (cpl) state_n = is_wr ? S_POLL_GO : S_DONE;
      S_POLL_GO:
        if (launch) state_n = S_POLL_WT;
      S_POLL_WT:
        if (cpl)
          state_n = (!wip || timeout) ? S_DONE
                                      : S_POLL_GAP;
      S_POLL_GAP:
        if (gap_end) state_n = S_POLL_GO;
      S_DONE:
        state_n = S_IDLE;
      default:
        state_n = S_IDLE;
    endcase
  end

  always_comb begin
    bus.command      = '0;
    bus.address      = '0;
    bus.data_in      = '0;
    bus.commtype     = '0;
    bus.ndata_bits   = '0;
    bus.frame_struct = '0;
    bus.dummy_cycles = '0;
    unique case (state)
      S_WREN_GO, S_WREN_WT: begin
        bus.command = 8'h06;
      end
      S_MAIN_GO, S_MAIN_WT: begin
        bus.command      = cmd_q;
        bus.address      = addr_q;
        bus.data_in      = data_q;
        bus.ndata_bits   = nbits_q;
        bus.frame_struct = frame_q;
        bus.dummy_cycles = dummy_q;
        if (op_q == 2'd1)      bus.commtype = 3'b100;
        else if (op_q == 2'd0) bus.commtype = 3'b010;
        else                   bus.commtype = 3'b000;
      end
      S_POLL_GO, S_POLL_WT: begin
        bus.command      = 8'h05;
        bus.commtype     = 3'b010;
        bus.ndata_bits   = 7'd8;
        bus.frame_struct = 10'h004;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      op_q       <= '0;
      cmd_q      <= '0;
      addr_q     <= '0;
      data_q     <= '0;
      nbits_q    <= '0;
      dummy_q    <= '0;
      frame_q    <= '0;
      cap_q      <= '0;
      rsp_data_q <= '0;
      poll_cnt   <= '0;
      gap_cnt    <= '0;
      seen_low_q <= 1'b0;
      vf_q       <= 1'b0;
      err_q      <= 1'b0;
    end else begin
      if (accept) begin
        op_q     <= bus.req_op;
        cmd_q    <= bus.req_cmd;
        addr_q   <= bus.req_addr;
        data_q   <= bus.req_data;
        nbits_q  <= bus.req_nbits;
        dummy_q  <= bus.req_dummy;
        frame_q  <= bus.req_frame;
        poll_cnt <= '0;
        err_q    <= 1'b0;
      end
      vf_q <= launch;
      if (launch) begin
        cap_q      <= '0;
        seen_low_q <= 1'b0;
      end else if (in_wt) begin
        if (!bus.tready)       seen_low_q <= 1'b1;
        if (bus.validflag_out) cap_q <= bus.data_out;
      end
      if (state == S_MAIN_WT && cpl)
        rsp_data_q <= cpl_data;
      if (state == S_POLL_WT && cpl) begin
        poll_cnt <= poll_cnt + 16'd1;
        if (wip && timeout) err_q <= 1'b1;
      end
      if (state == S_POLL_GAP) gap_cnt <= gap_cnt + 16'd1;
      else                     gap_cnt <= '0;
    end
  end

endmodule

// File: tb/tb_spi_fl_op_seq.sv
// Bench for spi_fl_op_seq: flash-master model plus a
// launch-list reference model, directed and random requests.
module tb_spi_fl_op_seq;
  localparam int GAP  = 16;
  localparam int MAXP = 4;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  spi_fl_op_seq_if bus ();

  spi_fl_op_seq #(
    .POLL_GAP (GAP),
    .MAX_POLLS(MAXP)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  typedef struct {
    logic [7:0]  cmd;
    logic [2:0]  ct;
    logic [23:0] addr;
    logic [31:0] din;
    logic [6:0]  nb;
    logic [9:0]  fr;
    logic [3:0]  dm;
    int          cyc;
    int          gap;
  } launch_t;

  typedef struct {
    logic [7:0] cmd;
    logic [2:0] ct;
    int         kind;
  } exp_t;

  launch_t     lq[$];
  exp_t        xq[$];
  logic [7:0]  m_stat[$];
  logic [7:0]  st_in[$];
  int          cyc = 0;
  int          last_rise = 0;
  int          acc_cyc = 0;
  int          rsp_n = 0;
  int          vf_low_n = 0;
  int          n_chk = 0;
  int          n_pass = 0;
  bit          m_hold = 1'b0;
  int          m_state = 0;
  int          m_cnt = 0;
  bit          m_same;
  logic [31:0] m_resp;
  logic [31:0] m_rdata = '0;
  logic [23:0] r_addr;
  logic [31:0] r_data;
  logic [6:0]  r_nb;
  logic [3:0]  r_dm;
  logic [9:0]  r_fr;
  logic [31:0] x_data;
  logic        x_err;

  task automatic chk(input string tag,
                     input logic [63:0] obs,
                     input logic [63:0] exp);
    n_chk++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s observed=%0h expected=%0h",
                tag, obs, exp);
  endtask

  initial forever begin
    @(posedge clk);
    cyc++;
  end

  // Flash master model and monitor share one negedge process.
  initial begin
    bus.tready        = 1'b1;
    bus.validflag_out = 1'b0;
    bus.data_out      = '0;
    forever begin
      @(negedge clk);
      if (bus.validflag && !bus.tready) vf_low_n++;
      if (bus.rsp_valid) rsp_n++;
      if (bus.validflag)
        lq.push_back('{bus.command, bus.commtype,
                       bus.address, bus.data_in,
                       bus.ndata_bits, bus.frame_struct,
                       bus.dummy_cycles, cyc,
                       cyc - last_rise});
      bus.validflag_out = 1'b0;
      case (m_state)
        0: begin
          if (bus.validflag && bus.tready) begin
            bus.tready = 1'b0;
            if (bus.command == 8'h05) begin
              if (m_stat.size() > 0)
                m_resp = {24'($urandom), m_stat.pop_front()};
              else
                m_resp = 32'h0;
            end else begin
              m_resp = m_rdata;
            end
            m_cnt   = int'($urandom_range(1, 4));
            m_same  = 1'($urandom_range(0, 1));
            m_state = 1;
          end else begin
            if (!bus.tready && !m_hold) last_rise = cyc;
            bus.tready = ~m_hold;
          end
        end
        1: begin
          m_cnt--;
          if (m_cnt == 0) begin
            bus.validflag_out = 1'b1;
            bus.data_out      = m_resp;
            if (m_same) begin
              bus.tready = 1'b1;
              last_rise  = cyc;
              m_state    = 0;
            end else begin
              m_state = 2;
            end
          end
        end
        default: begin
          bus.tready = 1'b1;
          last_rise  = cyc;
          m_state    = 0;
        end
      endcase
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog time limit");
    $fatal(1, "watchdog");
  end

  task automatic issue(input logic [1:0]  op,
                       input logic [7:0]  cmd,
                       input logic [23:0] addr,
                       input logic [31:0] data,
                       input logic [6:0]  nb,
                       input logic [3:0]  dm,
                       input logic [9:0]  fr,
                       input logic [31:0] rd);
    logic w;
    logic [2:0] ct;
    @(negedge clk);
    lq.delete();
    xq.delete();
    rsp_n    = 0;
    vf_low_n = 0;
    m_stat   = st_in;
    m_rdata  = rd;
    r_addr = addr; r_data = data; r_nb = nb;
    r_dm   = dm;   r_fr   = fr;
    w  = (op == 2'd1) || (op == 2'd2);
    ct = (op == 2'd1) ? 3'b100 :
         (op == 2'd0) ? 3'b010 : 3'b000;
    if (w) xq.push_back('{8'h06, 3'b000, 0});
    xq.push_back('{cmd, ct, 1});
    x_data = rd;
    x_err  = 1'b0;
    if (w)
      for (int k = 0; k < MAXP; k++) begin
        xq.push_back('{8'h05, 3'b010, 2});
        if (k >= st_in.size() || !st_in[k][0]) break;
        if (k == MAXP - 1) x_err = 1'b1;
      end
    bus.req_valid = 1'b1;
    bus.req_op    = op;
    bus.req_cmd   = cmd;
    bus.req_addr  = addr;
    bus.req_data  = data;
    bus.req_nbits = nb;
    bus.req_dummy = dm;
    bus.req_frame = fr;
    @(posedge clk);
    @(negedge clk);
    acc_cyc       = cyc;
    bus.req_valid = 1'b0;
    bus.req_cmd   = 8'($urandom);
    bus.req_addr  = 24'($urandom);
    bus.req_data  = $urandom;
    bus.req_nbits = 7'($urandom);
    bus.req_frame = 10'($urandom);
    chk("ready_drop", 64'(bus.req_ready), 64'(0));
    chk("busy_up", 64'(bus.busy), 64'(1));
  endtask

  task automatic finish_req(input bit bp);
    bit got;
    int n;
    got = 1'b0;
    for (int i = 0; i < 4000; i++) begin
      @(negedge clk);
      if (bus.rsp_valid) begin
        got = 1'b1;
        break;
      end
    end
    chk("rsp_seen", 64'(got), 64'(1));
    if (got) begin
      chk("rsp_data", 64'(bus.rsp_data), 64'(x_data));
      chk("rsp_err", 64'(bus.rsp_err), 64'(x_err));
      chk("busy_done", 64'(bus.busy), 64'(1));
      @(negedge clk);
      chk("ready_back", 64'(bus.req_ready), 64'(1));
      chk("busy_low", 64'(bus.busy), 64'(0));
      chk("rsp_pulse", 64'(bus.rsp_valid), 64'(0));
      chk("idle_cmd", 64'(bus.command), 64'(0));
      chk("idle_ct", 64'(bus.commtype), 64'(0));
      chk("idle_addr", 64'(bus.address), 64'(0));
    end
    repeat (3) @(negedge clk);
    chk("rsp_count", 64'(rsp_n), 64'(1));
    chk("vf_low", 64'(vf_low_n), 64'(0));
    chk("n_launch", 64'(lq.size()), 64'(xq.size()));
    n = (lq.size() < xq.size()) ? lq.size() : xq.size();
    for (int i = 0; i < n; i++) begin
      chk("l_cmd", 64'(lq[i].cmd), 64'(xq[i].cmd));
      chk("l_ct", 64'(lq[i].ct), 64'(xq[i].ct));
      if (xq[i].kind == 1) begin
        chk("l_addr", 64'(lq[i].addr), 64'(r_addr));
        chk("l_din", 64'(lq[i].din), 64'(r_data));
        chk("l_nb", 64'(lq[i].nb), 64'(r_nb));
        chk("l_fr", 64'(lq[i].fr), 64'(r_fr));
        chk("l_dm", 64'(lq[i].dm), 64'(r_dm));
      end else begin
        chk("l_nb", 64'(lq[i].nb),
            64'((xq[i].kind == 2) ? 8 : 0));
        chk("l_fr", 64'(lq[i].fr),
            64'((xq[i].kind == 2) ? 4 : 0));
        chk("l_dm", 64'(lq[i].dm), 64'(0));
      end
      if (i == 0 && bp)
        chk("bp_launch", 64'(lq[i].gap), 64'(1));
      else if (i == 0)
        chk("acc_lat", 64'(lq[i].cyc - acc_cyc), 64'(1));
      else if (xq[i].kind == 2 && xq[i-1].kind == 2)
        chk("poll_gap", 64'(lq[i].gap), 64'(GAP + 2));
      else
        chk("seq_gap", 64'(lq[i].gap), 64'(2));
    end
  endtask

  task automatic chk_reset_vals(input string tag);
    chk({tag, "_ready"}, 64'(bus.req_ready), 64'(1));
    chk({tag, "_busy"}, 64'(bus.busy), 64'(0));
    chk({tag, "_rspv"}, 64'(bus.rsp_valid), 64'(0));
    chk({tag, "_err"}, 64'(bus.rsp_err), 64'(0));
    chk({tag, "_rspd"}, 64'(bus.rsp_data), 64'(0));
    chk({tag, "_vf"}, 64'(bus.validflag), 64'(0));
    chk({tag, "_cmd"}, 64'(bus.command), 64'(0));
    chk({tag, "_addr"}, 64'(bus.address), 64'(0));
    chk({tag, "_din"}, 64'(bus.data_in), 64'(0));
    chk({tag, "_ct"}, 64'(bus.commtype), 64'(0));
    chk({tag, "_nb"}, 64'(bus.ndata_bits), 64'(0));
    chk({tag, "_fr"}, 64'(bus.frame_struct), 64'(0));
    chk({tag, "_dm"}, 64'(bus.dummy_cycles), 64'(0));
  endtask

  initial begin
    bit          got;
    logic [1:0]  op;
    logic [7:0]  cmd;
    int          ns;

    rst           = 1'b0;
    bus.req_valid = 1'b0;
    bus.req_op    = '0;
    bus.req_cmd   = '0;
    bus.req_addr  = '0;
    bus.req_data  = '0;
    bus.req_nbits = '0;
    bus.req_dummy = '0;
    bus.req_frame = '0;
    repeat (3) @(negedge clk);
    chk_reset_vals("por");
    rst = 1'b1;

    // read
    st_in.delete();
    issue(2'd0, 8'h03, 24'h555555, 32'h0, 7'd8, 4'd0,
          10'h004, 32'h000000A3);
    finish_req(1'b0);

    // page program with two busy polls
    st_in = '{8'h01, 8'h01, 8'h00};
    issue(2'd1, 8'h02, 24'h000100, 32'h5A000000, 7'd8,
          4'd0, 10'h190, 32'h00000000);
    finish_req(1'b0);

    // erase stuck busy
    st_in.delete();
    repeat (10) st_in.push_back(8'h01);
    issue(2'd2, 8'h20, 24'h010000, 32'h0, 7'd0, 4'd0,
          10'h300, 32'h00000000);
    finish_req(1'b0);

    // backpressure plus ignored second request
    m_hold = 1'b1;
    repeat (2) @(negedge clk);
    st_in.delete();
    issue(2'd0, 8'h0B, 24'h123456, 32'h0, 7'd32, 4'd8,
          10'h1A4, 32'hCAFEF00D);
    for (int i = 0; i < 50; i++) begin
      @(negedge clk);
      if (i == 10) begin
        bus.req_valid = 1'b1;
        bus.req_op    = 2'd2;
        bus.req_cmd   = 8'hD8;
      end
      if (i == 15) bus.req_valid = 1'b0;
    end
    chk("bp_no_launch", 64'(lq.size()), 64'(0));
    chk("bp_busy", 64'(bus.busy), 64'(1));
    m_hold = 1'b0;
    finish_req(1'b1);

    // reset during the poll gap
    st_in = '{8'h01, 8'h03, 8'h01, 8'h00};
    issue(2'd1, 8'h02, 24'h000200, 32'h11223344, 7'd32,
          4'd0, 10'h190, 32'h0000BEEF);
    got = 1'b0;
    for (int i = 0; i < 1000; i++) begin
      @(negedge clk);
      if (lq.size() >= 3) begin
        got = 1'b1;
        break;
      end
    end
    chk("rst_reach_poll", 64'(got), 64'(1));
    repeat (10) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    chk_reset_vals("mid");
    repeat (40) @(negedge clk);
    chk("mid_no_rsp", 64'(rsp_n), 64'(0));
    chk("mid_launches", 64'(lq.size()), 64'(3));
    st_in.delete();
    issue(2'd3, 8'h66, 24'h0, 32'h0, 7'd0, 4'd0,
          10'h000, 32'h00000066);
    finish_req(1'b0);

    // random requests against the launch-list model
    repeat (12) begin
      op  = 2'($urandom);
      cmd = 8'($urandom);
      if (cmd == 8'h05) cmd = 8'h9F;
      st_in.delete();
      ns = int'($urandom_range(0, 5));
      for (int k = 0; k < ns; k++)
        st_in.push_back({7'($urandom),
                         1'($urandom_range(0, 2) != 0)});
      issue(op, cmd, 24'($urandom), $urandom,
            7'($urandom), 4'($urandom), 10'($urandom),
            $urandom);
      finish_req(1'b0);
    end

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule

// File: doc/spi_fl_op_seq.md
# spi_fl_op_seq

Flash operation sequencer directly upstream of `spi_master_fl`. It accepts one high-level flash request (read, page program, erase, raw command) and expands it into the SPI transaction sequence the flash needs: write-enable, main command, then status polling until write-in-progress clears. It drives the master's controller port (`command`, `address`, `data_in`, `commtype`, `ndata_bits`, `frame_struct`, `dummy_cycles`, `validflag`) and consumes `data_out`, `validflag_out`, `tready`.

## Interface
- `POLL_GAP`, 16: idle clk cycles between consecutive status polls.
- `MAX_POLLS`, 1000: status reads before a timeout error is reported.
- `clk` in 1: single clock; everything is sampled on its rising edge.
- `rst` in 1: synchronous, active-low reset.
- `req_valid` in 1: request present.
- `req_ready` out 1: high only in IDLE.
- `req_op` in 2: 0 read, 1 program, 2 erase, 3 raw (main command only).
- `req_cmd` in 8, `req_addr` in 24, `req_data` in 32, `req_nbits` in 7, `req_dummy` in 4, `req_frame` in 10: main-transaction fields.
- `rsp_valid` out 1: one-cycle completion pulse.
- `rsp_data` out 32: `data_out` captured from the main transaction.
- `rsp_err` out 1: timeout flag, qualified by `rsp_valid`.
- `busy` out 1: high whenever not IDLE.
- `command` out 8, `address` out 24, `data_in` out 32, `commtype` out 3, `ndata_bits` out 7, `frame_struct` out 10, `dummy_cycles` out 4: master fields.
- `validflag` out 1: one-cycle launch pulse to the master.
- `data_out` in 32, `validflag_out` in 1, `tready` in 1: from the master.

## Operation
- States: IDLE, WREN_GO, WREN_WT, MAIN_GO, MAIN_WT, POLL_GO, POLL_WT, POLL_GAP, DONE.
- The request is accepted on `req_valid && req_ready`. All `req_*` fields are latched, so later changes on them are ignored.
- Routing out of IDLE:
  - op 1 and op 2 go to WREN_GO.
  - op 0 and op 3 go to MAIN_GO.
- Field values by transaction:
  - WREN: `command` 8'h06, `commtype` 3'b000, `ndata_bits` 0, `frame_struct` 0, `dummy_cycles` 0.
  - MAIN: the latched request fields. `commtype` is 3'b100 for program, 3'b010 for read, 3'b000 for erase and raw.
  - POLL: `command` 8'h05, `commtype` 3'b010, `ndata_bits` 8, `frame_struct` 10'h004, `dummy_cycles` 0.
- Field outputs hold their value for the whole transaction. They are zero in IDLE.
- *_GO states:
  - Wait for `tready`=1.
  - Assert `validflag` for exactly one cycle.
  - Then enter *_WT.
- *_WT states:
  - Wait for `tready` to go low, then wait for it to return high. That rising edge marks completion.
  - Any `validflag_out`=1 seen in the wait latches `data_out`.
  - A transaction completes only after its launch has been observed (`tready` low seen).
- After completion:
  - WREN_WT goes to MAIN_GO.
  - MAIN_WT goes to POLL_GO for op 1 and op 2, and to DONE for op 0 and op 3.
  - The captured main data goes to `rsp_data`.
- POLL_WT completion:
  - If status bit 0 (WIP) is 0, go to DONE.
  - If WIP is 1 and the poll counter has reached MAX_POLLS, set the error flag and go to DONE.
  - Otherwise go to POLL_GAP.
- POLL_GAP counts POLL_GAP cycles, then goes to POLL_GO.
- The 16-bit poll counter clears on request accept and increments on each POLL_WT completion.
- DONE asserts `rsp_valid` for one cycle and then returns to IDLE. The error flag clears on the next accept.

## Timing
- Reset values: state IDLE, `req_ready` 1, `busy` 0, `rsp_valid` 0, `rsp_err` 0, `rsp_data` 0, `validflag` 0, all field outputs 0, counters 0.
- Launch timing:
  - When `tready` is already high, `validflag` rises in the 2nd cycle after the accept edge.
  - `validflag` is never asserted while `tready`=0.
- `req_ready` drops the cycle after accept. It rises again the cycle after the `rsp_valid` pulse.
- A request is ignored if `req_valid` is high while `req_ready`=0.
- If `tready` rises and `validflag_out` pulses in the same cycle, the data is captured and completion is recognised in that cycle.
- Reset low mid-sequence:
  - The next edge forces the reset values and aborts the sequence with no `rsp_valid`.
  - Any in-flight master transaction is not tracked further.
- POLL_GAP=0: the gap state lasts 1 cycle.
- MAX_POLLS=1: the first busy status produces the timeout.

## Test plan
- Read: op 0, cmd 8'h03, addr 24'h555555, nbits 8, frame 10'h004, master model returns 32'hA3. Required: exactly one `validflag` pulse, `command`=8'h03, `rsp_valid` with `rsp_data`=32'hA3 and `rsp_err`=0.
- Program: op 1, cmd 8'h02, addr 24'h000100, data 32'h5A000000, frame 10'h190, status model returns WIP 1,1,0. Required: launch order 06 → 02 → 05 ×3; two POLL_GAP intervals of 16 cycles each; one `rsp_valid` with `rsp_err`=0.
- Timeout: MAX_POLLS=4, erase op 2 with cmd 8'h20, status stuck at 8'h01. Required: exactly 4 RDSR launches, then `rsp_valid` with `rsp_err`=1, then `req_ready` high.
- Backpressure: hold `tready` low 50 cycles after accept. Required: `validflag` stays 0 throughout and pulses once on the first cycle after `tready` rises; a second `req_valid` during `busy` is ignored.
- Reset mid-poll: drive `rst` low during POLL_GAP for 1 cycle. Required: next cycle shows all reset values and no `rsp_valid`; a following op 3 request (cmd 8'h66) completes normally.
